ws2812_frame_sequencer: RTL and testbench

WS2812_FRAME_SEQUENCER -- requirements
Module: ws2812_frame_sequencer

---
 rtl/ws2812_pkg.sv | 6 +
 rtl/ws2812_frame_sequencer_if.sv | 23 ++
 rtl/ws2812_latch_timer.sv | 18 +
 rtl/ws2812_frame_sequencer.sv | 67 ++++++
 tb/tb_ws2812_frame_sequencer.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state encoding and default sizing for the WS2812 frame sequencer
package ws2812_pkg;
  localparam int DEF_NUM_LEDS = 64;
  localparam int DEF_RESET_CYCLES = 500;
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, PRESENT, LATCH} state_e;
endpackage

// File: rtl/ws2812_frame_sequencer_if.sv
// ws2812_frame_sequencer_if: host write port, pixel RAM port and byte stream of the sequencer
interface ws2812_frame_sequencer_if;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_we;
  logic       host_ack;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic       ram_clear;
  logic [7:0] ram_rdata;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  modport master (
    input  host_addr, host_wdata, host_we, ram_rdata, byte_ready,
    output host_ack, ram_addr, ram_wdata, ram_we, ram_clear, byte_data, byte_valid
  );
  modport slave (
    output host_addr, host_wdata, host_we, ram_rdata, byte_ready,
    input  host_ack, ram_addr, ram_wdata, ram_we, ram_clear, byte_data, byte_valid
  );
endinterface

// File: rtl/ws2812_latch_timer.sv
// ws2812_latch_timer: latch-gap counter, zeroed by start, counting while en, done on its last cycle
module ws2812_latch_timer
  import ws2812_pkg::*;
#(
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int CW = $clog2(RESET_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic done
);
  logic [CW-1:0] count_q, count_d;
  always_comb count_d = start ? '0 : en ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
  assign done = en && count_q == CW'(RESET_CYCLES - 1);
endmodule

// File: rtl/ws2812_frame_sequencer.sv
// ws2812_frame_sequencer: streams pixel RAM bytes in address order to a bit serializer, then holds the latch gap
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear_req,
  ws2812_frame_sequencer_if.master bus,
  output logic busy,
  output logic frame_done
);
  localparam logic [7:0] LAST = 8'(3 * NUM_LEDS - 1);
  state_e state_q, state_d;
  logic [7:0] idx_q, idx_d, byte_q, byte_d;
  logic clr, fwd, last_xfer, lt_done;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    byte_d = byte_q;
    case (state_q)
      IDLE: if (start && !clear_req) begin
        idx_d = 8'h00;
        state_d = FETCH;
      end
      FETCH: state_d = CAPTURE;
      CAPTURE: begin
        byte_d = bus.ram_rdata;
        state_d = PRESENT;
      end
      PRESENT: if (bus.byte_ready) begin
        state_d = idx_q == LAST ? LATCH : FETCH;
        idx_d = idx_q == LAST ? idx_q : idx_q + 8'd1;
      end
      LATCH: if (lt_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    idx_q <= rst ? 8'h00 : idx_d;
    byte_q <= rst ? 8'h00 : byte_d;
  end
  // reset gating keeps host writes and pulses from leaking through in the reset cycle
  assign clr = state_q == IDLE && clear_req && !rst;
  assign fwd = bus.host_we && state_q != FETCH && !clr && !rst;
  assign last_xfer = state_q == PRESENT && bus.byte_ready && idx_q == LAST;
  assign bus.ram_clear = clr;
  assign bus.ram_we = fwd;
  assign bus.host_ack = fwd;
  assign bus.ram_addr = state_q == FETCH ? idx_q : fwd ? bus.host_addr : 8'h00;
  assign bus.ram_wdata = fwd ? bus.host_wdata : 8'h00;
  assign bus.byte_valid = state_q == PRESENT;
  assign bus.byte_data = byte_q;
  assign busy = state_q != IDLE;
  assign frame_done = lt_done && !rst;
  ws2812_latch_timer #(.RESET_CYCLES(RESET_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .start(last_xfer),
    .en(state_q == LATCH),
    .done(lt_done)
  );
endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// tb_ws2812_frame_sequencer: directed vectors against a small RAM model, NUM_LEDS=2, RESET_CYCLES=10
module tb_ws2812_frame_sequencer;
  logic clk = 0, rst = 1, start = 0, clear_req = 0;
  logic busy, frame_done;
  int vectors = 0, miscompares = 0;
  int cyc = 0, nd = 0, last_x = 0, done_c = 0;
  logic [7:0] q[$];
  logic [7:0] mem [256];
  ws2812_frame_sequencer_if bus();
  ws2812_frame_sequencer #(.NUM_LEDS(2), .RESET_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .clear_req(clear_req),
    .bus(bus.master), .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.ram_clear) foreach (mem[i]) mem[i] <= 8'h00;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.byte_valid && bus.byte_ready) begin
      q.push_back(bus.byte_data);
      last_x <= cyc;
    end
    if (frame_done) begin
      nd <= nd + 1;
      done_c <= cyc;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic preload();
    for (int i = 0; i < 6; i++) begin
      bus.host_we = 1; bus.host_addr = 8'(i); bus.host_wdata = 8'(8'h10 + i);
      #1 check("preload_ack", bus.host_ack, 1);
      tick();
    end
    bus.host_we = 0;
  endtask
  task automatic wait_done(input string tag, input int n0);
    int k = 0;
    while (nd == n0 && k < 200) begin tick(); k++; end
    check(tag, k < 200, 1);
  endtask
  task automatic run_frame(input string tag, output int qs);
    int n0 = nd;
    qs = q.size();
    start = 1; tick(); start = 0;
    wait_done(tag, n0);
    tick();
  endtask
  initial begin
    int k, qs, n0;
    logic stable;
    bus.host_we = 1; bus.host_addr = 8'h33; bus.host_wdata = 8'h77; bus.byte_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", bus.byte_valid, 0);
    check("rst_data", bus.byte_data, 0);
    check("rst_done", frame_done, 0);
    check("rst_we", bus.ram_we, 0);
    check("rst_clear", bus.ram_clear, 0);
    check("rst_ack", bus.host_ack, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_wdata", bus.ram_wdata, 0);
    rst = 0; bus.host_we = 0;
    tick();
    preload();
    // frame 1: latency, order, latch gap
    qs = q.size(); n0 = nd;
    start = 1; tick(); start = 0;
    check("fetch_busy", busy, 1);
    check("fetch_addr", bus.ram_addr, 0);
    k = 1;
    while (!bus.byte_valid && k < 20) begin tick(); k++; end
    check("latency", k, 3);
    wait_done("f1_timeout", n0);
    tick();
    check("f1_count", q.size() - qs, 6);
    for (int i = 0; i < 6; i++) check("f1_byte", q[qs + i], 8'h10 + i);
    check("f1_gap", done_c - last_x, 10);
    check("f1_pulses", nd - n0, 1);
    check("f1_idle", busy, 0);
    // frame 2: stall in PRESENT, host write colliding with FETCH
    qs = q.size(); n0 = nd;
    bus.byte_ready = 0;
    start = 1; tick(); start = 0;
    k = 0;
    while (!bus.byte_valid && k < 20) begin tick(); k++; end
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus.byte_valid || bus.byte_data !== 8'h10) stable = 0;
    end
    check("stall_stable", stable, 1);
    check("stall_noxfer", q.size() - qs, 0);
    bus.byte_ready = 1; tick();
    bus.host_we = 1; bus.host_addr = 8'h05; bus.host_wdata = 8'hAB;
    #1 check("fetch_ack", bus.host_ack, 0);
    check("fetch_prio_addr", bus.ram_addr, 1);
    tick();
    check("retry_ack", bus.host_ack, 1);
    check("retry_addr", bus.ram_addr, 5);
    check("retry_wdata", bus.ram_wdata, 8'hAB);
    tick(); bus.host_we = 0;
    wait_done("f2_timeout", n0);
    tick();
    check("f2_count", q.size() - qs, 6);
    check("f2_byte1", q[qs + 1], 8'h11);
    check("f2_byte5", q[qs + 5], 8'hAB);
    // later frame still carries the host write
    run_frame("f3_timeout", qs);
    check("f3_byte5", q[qs + 5], 8'hAB);
    check("f3_byte4", q[qs + 4], 8'h14);
    // clear_req wins over start in IDLE
    qs = q.size();
    clear_req = 1; start = 1;
    #1 check("clr_pulse", bus.ram_clear, 1);
    check("clr_busy", busy, 0);
    tick(); clear_req = 0; start = 0;
    #1 check("clr_once", bus.ram_clear, 0);
    repeat (10) tick();
    check("clr_busy_after", busy, 0);
    check("clr_nobytes", q.size() - qs, 0);
    run_frame("f4_timeout", qs);
    check("f4_cleared", q[qs + 5], 8'h00);
    preload();
    // reset mid-frame
    qs = q.size();
    start = 1; tick(); start = 0;
    k = 0;
    while (q.size() - qs < 2 && k < 50) begin tick(); k++; end
    rst = 1; tick(); rst = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", bus.byte_valid, 0);
    check("mid_rst_data", bus.byte_data, 0);
    run_frame("f5_timeout", qs);
    check("f5_count", q.size() - qs, 6);
    check("f5_byte0", q[qs], 8'h10);
    // start during LATCH is dropped
    qs = q.size(); n0 = nd;
    start = 1; tick(); start = 0;
    k = 0;
    while (q.size() - qs < 6 && k < 50) begin tick(); k++; end
    tick(); tick();
    start = 1; tick(); start = 0;
    check("latch_busy", busy, 1);
    repeat (40) tick();
    check("latch_pulses", nd - n0, 1);
    check("latch_nobytes", q.size() - qs, 6);
    check("latch_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
